// File: rtl/ahb_sram_subordinate.sv
// ahb_sram_subordinate: AHB-Lite subordinate backed by a word-organised SRAM
// array with a fixed number of wait states inserted in every OKAY data phase.
//
// Ports:
//   HCLK, HRESETn      clock, synchronous active-low reset
//   HSEL, HADDR,       address phase: select, byte address, transfer type,
//   HTRANS, HWRITE,    direction, size, and bus-level ready
//   HSIZE, HREADY
//   HWDATA             write data (data phase)
//   HREADYOUT, HRESP,  registered data-phase response and read data
//   HRDATA
//
// Optional feature macro: AHB_SRAM_SUB_ERROR_EN
//   defined   - size/alignment/range violations get a two-cycle ERROR response
//   undefined - violations complete as OKAY, writes are dropped, reads return 0
module ahb_sram_subordinate #(
    parameter int unsigned AddressWidth  = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned MemDepthWords = 256,
    parameter int unsigned WaitStates    = 0
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    HSEL,
    input  logic [AddressWidth-1:0] HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [DataWidth-1:0]    HWDATA,
    input  logic                    HREADY,
    output logic                    HREADYOUT,
    output logic [DataWidth-1:0]    HRDATA,
    output logic                    HRESP
);

    localparam int unsigned IdxW   = $clog2(MemDepthWords);
    localparam int unsigned AddrQW = IdxW + 2;
    localparam int unsigned CntW   = 4;
    localparam int unsigned LaneN  = DataWidth / 8;
    localparam logic [CntW-1:0] WaitLoad = CntW'((WaitStates > 0) ? WaitStates - 1 : 0);

`ifdef AHB_SRAM_SUB_ERROR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [AddrQW-1:0]     addr_q, addr_d;
    logic                  write_q, write_d;
    logic [2:0]            size_q, size_d;
    logic                  err_q, err_d;
    logic                  hreadyout_q, hreadyout_d;
    logic                  hresp_q, hresp_d;
    logic [DataWidth-1:0]  hrdata_q, hrdata_d;

    logic [DataWidth-1:0]  mem [MemDepthWords];

    logic                  addr_valid_c;
    logic                  err_det_c;
    logic                  accept_c;
    logic [LaneN-1:0]      be_c;
    logic [DataWidth-1:0]  mask_c;
    logic                  wr_en_c;
    logic [IdxW-1:0]       wr_idx_c;
    logic [IdxW-1:0]       rd_idx_c;
    logic [DataWidth-1:0]  wr_word_c;
    logic [DataWidth-1:0]  rd_word_c;
    logic                  unused_trans_c;

    // HTRANS[0] only distinguishes SEQ from NONSEQ and BUSY from IDLE.
    assign unused_trans_c = HTRANS[0];

    // Address-phase qualification and violation detection.
    assign addr_valid_c = HSEL & HREADY & HTRANS[1];
    assign err_det_c    = (HSIZE > 3'd2)
                        | ((HSIZE == 3'd1) & HADDR[0])
                        | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00))
                        | ((HADDR >> AddrQW) != '0);

    // Byte enables and the merged word for the write committing this cycle.
    always_comb begin
        be_c = '0;
        case (size_q)
            3'd0:    be_c = LaneN'(1) << addr_q[1:0];
            3'd1:    be_c = addr_q[1] ? LaneN'(4'b1100) : LaneN'(4'b0011);
            default: be_c = '1;
        endcase
        for (int i = 0; i < int'(LaneN); i++) begin
            mask_c[8*i +: 8] = {8{be_c[i]}};
        end
        wr_en_c   = (state_q == S_DATA) & write_q & ~err_q;
        wr_idx_c  = addr_q[AddrQW-1:2];
        wr_word_c = (mem[wr_idx_c] & ~mask_c) | (HWDATA & mask_c);
    end

    // Next-state, captured address phase and registered response.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        write_d     = write_q;
        size_d      = size_q;
        err_d       = err_q;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b0;
        hrdata_d    = '0;
        accept_c    = 1'b0;
        rd_idx_c    = '0;
        rd_word_c   = '0;

        case (state_q)
            S_IDLE: accept_c = addr_valid_c;
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            S_DATA, S_ERR2: begin
                state_d  = S_IDLE;
                accept_c = addr_valid_c;
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase

        if (accept_c) begin
            addr_d  = HADDR[AddrQW-1:0];
            write_d = HWRITE;
            size_d  = HSIZE;
            err_d   = err_det_c;
            if (ErrEn && err_det_c) begin
                state_d = S_ERR1;
            end else if (WaitStates > 0) begin
                state_d = S_WAIT;
                cnt_d   = WaitLoad;
            end else begin
                state_d = S_DATA;
            end
        end

        hreadyout_d = (state_d != S_WAIT) && (state_d != S_ERR1);
        hresp_d     = (state_d == S_ERR1) || (state_d == S_ERR2);

        // Forward a same-word write committing on this edge into the read.
        rd_idx_c  = addr_d[AddrQW-1:2];
        rd_word_c = (wr_en_c && (wr_idx_c == rd_idx_c)) ? wr_word_c : mem[rd_idx_c];
        if ((state_d == S_DATA) && !write_d && !err_d) begin
            hrdata_d = rd_word_c;
        end
    end

    // Control and output registers.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            size_q      <= '0;
            err_q       <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            size_q      <= size_d;
            err_q       <= err_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
        end
    end

    // Storage array; not reset, and reset drops a write in flight.
    always_ff @(posedge HCLK) begin
        if (HRESETn && wr_en_c) begin
            mem[wr_idx_c] <= wr_word_c;
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_q;

endmodule

// File: doc/ahb_sram_subordinate.md
# ahb_sram_subordinate

Synthesizable AHB-Lite subordinate with a word-organised SRAM array and configurable wait-state insertion. It sits directly downstream of `ahb_manager_synth` and replaces the Renode-backed subordinate when a self-contained target is needed. It is also used alongside that subordinate to check manager timing against a known-latency memory. It decodes AHB-Lite address/data phases, performs byte/halfword/word accesses, and drives `HREADYOUT`/`HRESP`.

## Interface
- `AddressWidth`, 32, width of `HADDR`
- `DataWidth`, 32, width of `HWDATA`/`HRDATA`; only 32 is supported
- `MemDepthWords`, 256, number of `DataWidth` words; must be a power of two
- `WaitStates`, 0, number of `HREADYOUT`-low cycles inserted in every OKAY data phase; 0..15

Ports:
- `HCLK` in 1: clock; all logic on the rising edge
- `HRESETn` in 1: synchronous active-low reset, sampled on the `HCLK` rising edge
- `HSEL` in 1: subordinate select
- `HADDR` in `AddressWidth`: byte address
- `HTRANS` in 2: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- `HWRITE` in 1: 1 = write
- `HSIZE` in 3: 0 byte, 1 halfword, 2 word
- `HWDATA` in `DataWidth`: write data, data phase
- `HREADY` in 1: bus ready (the mux-ed `HREADYOUT`)
- `HREADYOUT` out 1: subordinate ready; reset 1
- `HRDATA` out `DataWidth`: read data; reset 0
- `HRESP` out 1: 0 OKAY, 1 ERROR; reset 0

## Operation
- Address phase accepted on an edge where `HSEL & HREADY & HTRANS[1]`. On acceptance the block registers addr, write, size and the error flag.
- IDLE/BUSY or unselected transfers: no access; next data phase is zero-wait OKAY.
- Word index = `HADDR[log2(MemDepthWords)+1:2]`.
- Error condition: `HSIZE > 2`, misalignment (halfword with `HADDR[0]`, word with `HADDR[1:0]!=0`), or any `HADDR` bit above the index range set.
- FSM states:
  - IDLE: `HREADYOUT`=1, `HRESP`=0.
  - IDLE -> WAIT on a valid access when `WaitStates>0`. IDLE -> DATA when `WaitStates==0`. IDLE -> ERR1 on an error.
  - WAIT: `HREADYOUT`=0, counter loads `WaitStates-1` and decrements. At 0 -> DATA.
  - DATA: `HREADYOUT`=1. A write commits at the edge ending DATA, using byte enables from the registered size and `addr[1:0]`. Next state: IDLE, or WAIT/DATA/ERR1 if a new address phase is accepted on the same edge (back-to-back).
  - ERR1: `HRESP`=1, `HREADYOUT`=0 -> ERR2.
  - ERR2: `HRESP`=1, `HREADYOUT`=1 -> IDLE. A new address phase may be accepted on the ERR2 edge. Errored writes do not modify memory.
- `HRDATA`: in read DATA, the full word `mem[index_q]` (all lanes; the manager selects the lane). Otherwise 0.
- Read-after-write to the same word, back-to-back: the read returns the new data.
- The array is not reset. Reset clears the FSM, counter and outputs, and discards a pending write.

## Timing
- Zero-wait read: address phase at edge N. `HRDATA`/`HREADYOUT`=1 valid in cycle N..N+1, sampled by the manager at edge N+1.
- With W wait states: `HREADYOUT` is low for exactly W cycles after the address edge. Data is sampled at edge N+1+W.
- Error: exactly 2 data-phase cycles (ERR1, ERR2) regardless of `WaitStates`.
- `HRESETn` low at any edge: at the following cycle all outputs are at reset values, even mid-WAIT or mid-ERR.

## Configuration
- `AHB_SRAM_SUB_ERROR_EN` defined: error conditions produce the two-cycle ERROR response as above.
- Undefined: no ERR states. Erroring accesses take the normal WAIT/DATA path with `HRESP` tied 0. Writes are dropped and reads return 0.

## Test plan
- Reset, then word write 0xDEADBEEF to 0x10, then read 0x10, `WaitStates`=0 -> `HRDATA`=0xDEADBEEF, no `HREADYOUT` low cycles.
- Byte write 0xAA to 0x13 over 0x11223344 -> word read returns 0xAA223344. Halfword write 0x5566 to 0x10 -> 0xAA225566.
- `WaitStates`=3, back-to-back write 0x0 then read 0x0 -> `HREADYOUT` low 3 cycles per transfer, read returns written data.
- `AHB_SRAM_SUB_ERROR_EN` defined, word read at 0x402 (misaligned) and 0x400 (out of range, 256 words) -> `HRESP`=1 for 2 cycles, `HREADYOUT` 0 then 1. Undefined -> OKAY with `HRDATA`=0.
- `HRESETn` asserted mid-WAIT of a write to 0x20 (old 0x12345678) -> `HREADYOUT`=1, `HRESP`=0 next cycle. A later read of 0x20 returns 0x12345678.
